// File: rtl/nand_stim_checker.sv
// nand_stim_checker: closed-loop stimulus driver and response checker for the
//   registered-NAND test circuit. Sweeps vectors 00,01,10,11 NUM_PASSES times,
//   predicts each response LAT cycles later and counts mismatches.
// Latency: start edge to done high = 4*NUM_PASSES + LAT cycles.
// Backpressure: none; start is a level request honoured only in IDLE or DONE,
//   ignored while busy. A held-high start in DONE gives back-to-back runs.
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   start               run request (level-sampled)
//   stim0, stim1        registered drives to DUT in0/in1
//   resp                DUT out0
//   busy, done, pass    status (RUN/DRAIN, DONE, DONE with zero errors)
//   err_cnt             saturating mismatch count for the current run
// Optional: define NAND_CHK_FIRST_ERR_EN to add first_err_valid/first_err_idx,
//   the vector index of the first mismatch in the current run.
module nand_stim_checker #(
  parameter int NUM_PASSES = 4,
  parameter int LAT        = 1,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             stim0,
  output logic             stim1,
  input  logic             resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef NAND_CHK_FIRST_ERR_EN
  ,
  output logic             first_err_valid,
  output logic [5:0]       first_err_idx
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int NVEC = 4 * NUM_PASSES;
  localparam int KW   = $clog2(NVEC + 1);
  localparam int DW   = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [KW-1:0]    K_END   = KW'(NVEC);
  localparam logic [DW-1:0]    D_END   = DW'(LAT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t        state;
  logic [KW-1:0] k;       // index of the next vector to launch while in RUN
  logic [DW-1:0] dcnt;

  // Expected-response pipeline: one stage per DUT register plus the stage
  // that lines the tail up with the edge at which resp is sampled.
  logic exp_pipe [0:LAT];
  logic vld_pipe [0:LAT];

  logic       start_ok;
  logic       push_vld;
  logic       push_exp;
  logic [1:0] vec_bits;
  logic       mismatch;

  always_comb begin
    start_ok = start && ((state == IDLE) || (state == DONE));
    push_vld = start_ok || ((state == RUN) && (k != K_END));
    // Vector 0 is launched from the start edge itself, before k advances.
    vec_bits = start_ok ? 2'b00 : k[1:0];
    push_exp = ~(vec_bits[1] & vec_bits[0]);
    mismatch = vld_pipe[LAT] && (resp != exp_pipe[LAT]);
  end

`ifdef NAND_CHK_FIRST_ERR_EN
  logic [5:0] idx_pipe [0:LAT];
  logic [5:0] push_idx;

  always_comb begin
    push_idx = start_ok ? 6'd0 : 6'(k);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= LAT; i++) idx_pipe[i] <= 6'd0;
      first_err_valid <= 1'b0;
      first_err_idx   <= 6'd0;
    end else begin
      idx_pipe[0] <= push_idx;
      for (int i = 1; i <= LAT; i++) idx_pipe[i] <= idx_pipe[i-1];
      if (start_ok) begin
        first_err_valid <= 1'b0;
        first_err_idx   <= 6'd0;
      end else if (mismatch && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_idx   <= idx_pipe[LAT];
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      dcnt    <= '0;
      stim0   <= 1'b0;
      stim1   <= 1'b0;
      err_cnt <= '0;
      for (int i = 0; i <= LAT; i++) begin
        exp_pipe[i] <= 1'b0;
        vld_pipe[i] <= 1'b0;
      end
    end else begin
      exp_pipe[0] <= push_exp;
      vld_pipe[0] <= push_vld;
      for (int i = 1; i <= LAT; i++) begin
        exp_pipe[i] <= exp_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end

      // A new run clears the count; the tail is never valid at that edge.
      if (start_ok) begin
        err_cnt <= '0;
      end else if (mismatch && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state <= RUN;
            stim0 <= 1'b0;
            stim1 <= 1'b0;
            k     <= KW'(1);
          end
        end
        RUN: begin
          if (k == K_END) begin
            state <= DRAIN;
            stim0 <= 1'b0;
            stim1 <= 1'b0;
            dcnt  <= '0;
          end else begin
            stim0 <= k[1];
            stim1 <= k[0];
            k     <= k + 1'b1;
          end
        end
        DRAIN: begin
          // The last in-flight compare lands on the same edge as this exit.
          if (dcnt == D_END) state <= DONE;
          else               dcnt  <= dcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_nand_stim_checker.sv
module tb_nand_stim_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  // main instance: NUM_PASSES=4, LAT=1, ERR_W=8
  logic       start_m, stim0_m, stim1_m, resp_m, busy_m, done_m, pass_m;
  logic [7:0] err_m;
  // saturation instance: ERR_W=2 against an AND gate
  logic       start_s, stim0_s, stim1_s, resp_s, busy_s, done_s, pass_s;
  logic [1:0] err_s;
  // latency instance: LAT=3 against a 3-stage NAND
  logic       start_l, stim0_l, stim1_l, resp_l, busy_l, done_l, pass_l;
  logic [7:0] err_l;
`ifdef NAND_CHK_FIRST_ERR_EN
  logic       fev_m, fev_s, fev_l;
  logic [5:0] fei_m, fei_s, fei_l;
`endif

  // DUT models: 0 good 1-stage NAND, 1 stuck-at-1, 2 AND, 3 good 3-stage NAND
  int   mode;
  logic m_nand, m_and, m_p1, m_p2, m_p3;
  logic s_and, l_p1, l_p2, l_p3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_nand <= 1'b1; m_and <= 1'b0;
      m_p1 <= 1'b1; m_p2 <= 1'b1; m_p3 <= 1'b1;
      s_and <= 1'b0;
      l_p1 <= 1'b1; l_p2 <= 1'b1; l_p3 <= 1'b1;
    end else begin
      m_nand <= ~(stim0_m & stim1_m);
      m_and  <= stim0_m & stim1_m;
      m_p1 <= ~(stim0_m & stim1_m); m_p2 <= m_p1; m_p3 <= m_p2;
      s_and  <= stim0_s & stim1_s;
      l_p1 <= ~(stim0_l & stim1_l); l_p2 <= l_p1; l_p3 <= l_p2;
    end
  end

  assign resp_m = (mode == 1) ? 1'b1 : (mode == 2) ? m_and : (mode == 3) ? m_p3 : m_nand;
  assign resp_s = s_and;
  assign resp_l = l_p3;

  nand_stim_checker #(.NUM_PASSES(4), .LAT(1), .ERR_W(8)) u_main (
    .clk(clk), .rst(rst), .start(start_m), .stim0(stim0_m), .stim1(stim1_m),
    .resp(resp_m), .busy(busy_m), .done(done_m), .pass(pass_m), .err_cnt(err_m)
`ifdef NAND_CHK_FIRST_ERR_EN
    , .first_err_valid(fev_m), .first_err_idx(fei_m)
`endif
  );

  nand_stim_checker #(.NUM_PASSES(4), .LAT(1), .ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .stim0(stim0_s), .stim1(stim1_s),
    .resp(resp_s), .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_s)
`ifdef NAND_CHK_FIRST_ERR_EN
    , .first_err_valid(fev_s), .first_err_idx(fei_s)
`endif
  );

  nand_stim_checker #(.NUM_PASSES(4), .LAT(3), .ERR_W(8)) u_lat3 (
    .clk(clk), .rst(rst), .start(start_l), .stim0(stim0_l), .stim1(stim1_l),
    .resp(resp_l), .busy(busy_l), .done(done_l), .pass(pass_l), .err_cnt(err_l)
`ifdef NAND_CHK_FIRST_ERR_EN
    , .first_err_valid(fev_l), .first_err_idx(fei_l)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start_m = v;
      1:       start_s = v;
      default: start_l = v;
    endcase
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0:       return done_m;
      1:       return done_s;
      default: return done_l;
    endcase
  endfunction

  function automatic logic [7:0] get_err(input int which);
    case (which)
      0:       return err_m;
      1:       return {6'd0, err_s};
      default: return err_l;
    endcase
  endfunction

  // Start a run and count edges from the start edge until done is seen.
  task automatic run(input int which, input bit glitch, output int n, output logic [7:0] err0);
    @(negedge clk); set_start(which, 1'b1);
    @(negedge clk); set_start(which, 1'b0);
    n    = 0;
    err0 = get_err(which);
    while (!get_done(which) && n < 100) begin
      set_start(which, glitch && (n == 3 || n == 10));
      @(negedge clk);
      n++;
    end
    set_start(which, 1'b0);
  endtask

  initial begin
    int         n;
    logic [7:0] e0;
    logic [3:0] kk;

    rst = 1'b1; mode = 0;
    start_m = 1'b0; start_s = 1'b0; start_l = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stim", {30'd0, stim0_m, stim1_m}, 32'd0);
    chk("rst_busy", {31'd0, busy_m}, 32'd0);
    chk("rst_done", {31'd0, done_m}, 32'd0);
    chk("rst_pass", {31'd0, pass_m}, 32'd0);
    chk("rst_err",  {24'd0, err_m}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Good DUT: exact stimulus order, busy window and done edge.
    @(negedge clk); start_m = 1'b1;
    @(negedge clk); start_m = 1'b0;
    for (int k = 0; k < 16; k++) begin
      kk = 4'(k);
      chk("run_stim", {30'd0, stim0_m, stim1_m}, {30'd0, kk[1], kk[0]});
      chk("run_busy", {31'd0, busy_m}, 32'd1);
      chk("run_done", {31'd0, done_m}, 32'd0);
      @(negedge clk);
    end
    chk("drain_stim", {30'd0, stim0_m, stim1_m}, 32'd0);
    chk("drain_busy", {31'd0, busy_m}, 32'd1);
    chk("drain_done", {31'd0, done_m}, 32'd0);
    @(negedge clk);
    chk("good_done", {31'd0, done_m}, 32'd1);
    chk("good_busy", {31'd0, busy_m}, 32'd0);
    chk("good_pass", {31'd0, pass_m}, 32'd1);
    chk("good_err",  {24'd0, err_m}, 32'd0);
`ifdef NAND_CHK_FIRST_ERR_EN
    chk("good_fev", {31'd0, fev_m}, 32'd0);
`endif

    // Stuck-at-1: only vector 11 mismatches, once per pass.
    mode = 1;
    run(0, 1'b0, n, e0);
    chk("stuck_lat",  n, 32'd17);
    chk("stuck_err",  {24'd0, err_m}, 32'd4);
    chk("stuck_pass", {31'd0, pass_m}, 32'd0);
`ifdef NAND_CHK_FIRST_ERR_EN
    chk("stuck_fev", {31'd0, fev_m}, 32'd1);
    chk("stuck_fei", {26'd0, fei_m}, 32'd3);
`endif

    // Restart from DONE clears err_cnt; starts during RUN are ignored.
    mode = 0;
    run(0, 1'b1, n, e0);
    chk("glitch_err0", {24'd0, e0}, 32'd0);
    chk("glitch_lat",  n, 32'd17);
    chk("glitch_err",  {24'd0, err_m}, 32'd0);
    chk("glitch_pass", {31'd0, pass_m}, 32'd1);

    // Reset in the middle of a run.
    mode = 1;
    @(negedge clk); start_m = 1'b1;
    @(negedge clk); start_m = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_err", {24'd0, err_m}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_stim", {30'd0, stim0_m, stim1_m}, 32'd0);
    chk("mrst_busy", {31'd0, busy_m}, 32'd0);
    chk("mrst_done", {31'd0, done_m}, 32'd0);
    chk("mrst_err",  {24'd0, err_m}, 32'd0);
    chk("mrst_busy_s", {31'd0, busy_s | busy_l}, 32'd0);
    chk("mrst_err_l",  {24'd0, err_l}, 32'd0);
    @(negedge clk); rst = 1'b0;
    mode = 0;
    run(0, 1'b0, n, e0);
    chk("post_rst_lat",  n, 32'd17);
    chk("post_rst_pass", {31'd0, pass_m}, 32'd1);

    // 3-stage DUT behind a LAT=1 checker: odd vectors 3..15 mismatch.
    mode = 3;
    run(0, 1'b0, n, e0);
    chk("latmis_err",  {24'd0, err_m}, 32'd7);
    chk("latmis_pass", {31'd0, pass_m}, 32'd0);

    // AND DUT with a 2-bit counter: 16 mismatches saturate at 3.
    run(1, 1'b0, n, e0);
    chk("sat_lat",  n, 32'd17);
    chk("sat_err",  {24'd0, get_err(1)}, 32'd3);
    chk("sat_pass", {31'd0, pass_s}, 32'd0);
`ifdef NAND_CHK_FIRST_ERR_EN
    chk("sat_fev", {31'd0, fev_s}, 32'd1);
    chk("sat_fei", {26'd0, fei_s}, 32'd0);
`endif

    // 3-stage DUT with a matching LAT=3 checker.
    run(2, 1'b0, n, e0);
    chk("lat3_lat",  n, 32'd19);
    chk("lat3_err",  {24'd0, err_l}, 32'd0);
    chk("lat3_pass", {31'd0, pass_l}, 32'd1);
    chk("lat3_stim", {30'd0, stim0_l, stim1_l}, 32'd0);
`ifdef NAND_CHK_FIRST_ERR_EN
    chk("lat3_fev", {31'd0, fev_l}, 32'd0);
    chk("lat3_fei", {26'd0, fei_l}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
